step_seq_ctrl: RTL and testbench

- Run/stop controller for the synth step sequencer. Holds a STEPS-entry pattern of note/gate registers and advances through them at a programmable tempo.
- Emits the current note, a timed gate and a step strobe to the voice/oscillator datapath.
- The pattern is programmed through a simple write port while stopped or running.

---
 rtl/step_seq_ctrl.sv | 141 ++++++++++++++
 tb/tb_step_seq_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_seq_ctrl.sv
// Run/stop step sequencer: STEPS-entry note/gate pattern played at a programmable tempo.
// Optional swing timing is built when STEP_SEQ_SWING_EN is defined.
module step_seq_ctrl #(
    parameter int STEPS  = 8,
    parameter int NOTE_W = 7,
    parameter int DIV_W  = 24,
    localparam int IDX_W = $clog2(STEPS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic [DIV_W-1:0]  tempo_div,
    input  logic [DIV_W-1:0]  gate_len,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [NOTE_W-1:0] wr_note,
    input  logic              wr_gate,
`ifdef STEP_SEQ_SWING_EN
    input  logic [DIV_W-2:0]  swing_amt,
`endif
    output logic [NOTE_W-1:0] note_out,
    output logic              gate_out,
    output logic [IDX_W-1:0]  step_idx,
    output logic              step_pulse,
    output logic              running
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    tick_q, tick_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic                gate_q, gate_d;
    logic                pulse_q, pulse_d;
    logic                load;
    logic [NOTE_W-1:0]   sel_note;
    logic                sel_gate;
    logic [NOTE_W-1:0]   pat_note [STEPS];
    logic                pat_gate [STEPS];

    logic [DIV_W-1:0]    eff_div;
    logic [DIV_W:0]      step_len;
    logic                last_tick;

    assign eff_div = (tempo_div < DIV_W'(2)) ? DIV_W'(2) : tempo_div;

`ifdef STEP_SEQ_SWING_EN
    logic [DIV_W-1:0] swing_max, swing_s;
    assign swing_max = (eff_div >> 1) - DIV_W'(1);
    assign swing_s   = ({1'b0, swing_amt} > swing_max) ? swing_max : {1'b0, swing_amt};
    // Even steps are lengthened and odd steps shortened by the same amount.
    assign step_len  = idx_q[0] ? ({1'b0, eff_div} - {1'b0, swing_s})
                                : ({1'b0, eff_div} + {1'b0, swing_s});
`else
    assign step_len  = {1'b0, eff_div};
`endif

    assign last_tick = ({1'b0, tick_q} == (step_len - (DIV_W+1)'(1)));

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        idx_d   = idx_q;
        note_d  = note_q;
        pulse_d = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                    tick_d  = '0;
                    idx_d   = '0;
                    pulse_d = 1'b1;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    tick_d  = '0;
                    idx_d   = '0;
                end else if (start) begin
                    tick_d  = '0;
                    idx_d   = '0;
                    pulse_d = 1'b1;
                    load    = 1'b1;
                end else if (last_tick) begin
                    tick_d  = '0;
                    idx_d   = idx_q + IDX_W'(1);
                    pulse_d = 1'b1;
                    load    = 1'b1;
                end else begin
                    tick_d  = tick_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Forward a same-cycle write so outputs see the pattern as it stands after this edge.
        sel_note = (wr_en && (wr_addr == idx_d)) ? wr_note : pat_note[idx_d];
        sel_gate = (wr_en && (wr_addr == idx_d)) ? wr_gate : pat_gate[idx_d];
        if (load) begin
            note_d = sel_note;
        end
        gate_d = (state_d == RUN) && sel_gate && (tick_d < gate_len);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            idx_q   <= '0;
            note_q  <= '0;
            gate_q  <= 1'b0;
            pulse_q <= 1'b0;
            for (int i = 0; i < STEPS; i++) begin
                pat_note[i] <= '0;
                pat_gate[i] <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            note_q  <= note_d;
            gate_q  <= gate_d;
            pulse_q <= pulse_d;
            if (wr_en) begin
                pat_note[wr_addr] <= wr_note;
                pat_gate[wr_addr] <= wr_gate;
            end
        end
    end

    assign note_out   = note_q;
    assign gate_out   = gate_q;
    assign step_idx   = idx_q;
    assign step_pulse = pulse_q;
    assign running    = (state_q == RUN);

endmodule

// File: tb/tb_step_seq_ctrl.sv
// Self-checking bench for step_seq_ctrl: directed scenarios plus randomized play against a step-level model.
// Swing checks are included when STEP_SEQ_SWING_EN is defined.
module tb_step_seq_ctrl;
    localparam int STEPS  = 8;
    localparam int NOTE_W = 7;
    localparam int DIV_W  = 24;
    localparam int IW     = 3;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0, stop = 1'b0;
    logic [DIV_W-1:0]  tempo_div = '0, gate_len = '0;
    logic              wr_en = 1'b0;
    logic [IW-1:0]     wr_addr = '0;
    logic [NOTE_W-1:0] wr_note = '0;
    logic              wr_gate = 1'b0;
`ifdef STEP_SEQ_SWING_EN
    logic [DIV_W-2:0]  swing_amt = '0;
`endif
    logic [NOTE_W-1:0] note_out;
    logic              gate_out;
    logic [IW-1:0]     step_idx;
    logic              step_pulse;
    logic              running;

    step_seq_ctrl #(.STEPS(STEPS), .NOTE_W(NOTE_W), .DIV_W(DIV_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .tempo_div(tempo_div), .gate_len(gate_len),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_note(wr_note), .wr_gate(wr_gate),
`ifdef STEP_SEQ_SWING_EN
        .swing_amt(swing_amt),
`endif
        .note_out(note_out), .gate_out(gate_out), .step_idx(step_idx),
        .step_pulse(step_pulse), .running(running)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    // Reference model: position within the current step and the step being played.
    int m_pn[STEPS];
    bit m_pg[STEPS];
    bit m_run, m_pulse, m_gate;
    int m_idx, m_pos, m_note;

    logic [NOTE_W+IW+2:0] act_v, exp_v;

    function automatic int step_cycles(int idx);
        int eff, s;
        eff = (tempo_div < 2) ? 2 : int'(tempo_div);
        s = 0;
`ifdef STEP_SEQ_SWING_EN
        s = (int'(swing_amt) < eff / 2 - 1) ? int'(swing_amt) : eff / 2 - 1;
`endif
        return (idx % 2 == 0) ? eff + s : eff - s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < STEPS; i++) begin
            m_pn[i] = 0;
            m_pg[i] = 0;
        end
        m_run = 0; m_pulse = 0; m_gate = 0;
        m_idx = 0; m_pos = 0; m_note = 0;
    endtask

    task automatic model_edge();
        if (wr_en) begin
            m_pn[wr_addr] = int'(wr_note);
            m_pg[wr_addr] = wr_gate;
        end
        m_pulse = 0;
        if (stop) begin
            m_run = 0; m_idx = 0; m_pos = 0;
        end else if (start) begin
            m_run = 1; m_idx = 0; m_pos = 0; m_pulse = 1; m_note = m_pn[0];
        end else if (m_run) begin
            if (m_pos + 1 >= step_cycles(m_idx)) begin
                m_pos = 0;
                m_idx = (m_idx + 1) % STEPS;
                m_pulse = 1;
                m_note = m_pn[m_idx];
            end else begin
                m_pos++;
            end
        end
        m_gate = m_run && m_pg[m_idx] && (m_pos < int'(gate_len));
    endtask

    task automatic clk_step();
        model_edge();
        @(posedge clk);
        #1;
        act_v = {note_out, gate_out, step_idx, step_pulse, running};
        exp_v = {NOTE_W'(m_note), m_gate, IW'(m_idx), m_pulse, m_run};
    endtask

    task automatic write_step(int addr, int note, bit g);
        wr_en = 1; wr_addr = IW'(addr); wr_note = NOTE_W'(note); wr_gate = g;
        clk_step();
        wr_en = 0;
    endtask

    task automatic do_start();
        start = 1;
        clk_step();
        start = 0;
    endtask

    task automatic do_stop();
        stop = 1;
        clk_step();
        stop = 0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({note_out, gate_out, step_idx, step_pulse, running} !== '0)
            $display("FAIL reset_outputs: got %h expected 0", {note_out, gate_out, step_idx, step_pulse, running});
        else n_pass++;
        reset_n = 1;
        clk_step();
        n_chk++;
        if (act_v !== exp_v) $display("FAIL reset_idle: got %h expected %h", act_v, exp_v);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [NOTE_W+IW+2:0] want;
        for (int i = 0; i < STEPS; i++) write_step(i, 10 + i, 1);
        tempo_div = 4; gate_len = 2;
        do_start();
        for (int c = 0; c < 33; c++) begin
            want = {NOTE_W'(10 + (c / 4) % 8), (c % 4) < 2, IW'((c / 4) % 8), (c % 4) == 0, 1'b1};
            n_chk++;
            if (act_v !== want) $display("FAIL basic_c%0d: got %h expected %h", c, act_v, want);
            else n_pass++;
            n_chk++;
            if (act_v !== exp_v) $display("FAIL basic_model_c%0d: got %h expected %h", c, act_v, exp_v);
            else n_pass++;
            clk_step();
        end
    endtask

    task automatic test_rest();
        logic [NOTE_W+IW+2:0] want;
        write_step(3, 13, 0);
        do_start();
        for (int c = 0; c < 36; c++) begin
            want = {NOTE_W'(10 + (c / 4) % 8), ((c % 4) < 2) && ((c / 4) % 8 != 3),
                    IW'((c / 4) % 8), (c % 4) == 0, 1'b1};
            n_chk++;
            if (act_v !== want) $display("FAIL rest_c%0d: got %h expected %h", c, act_v, want);
            else n_pass++;
            clk_step();
        end
    endtask

    task automatic test_start_stop();
        logic [NOTE_W-1:0] held;
        repeat (5) clk_step();
        held = note_out;
        start = 1; stop = 1;
        clk_step();
        start = 0; stop = 0;
        n_chk++;
        if ({note_out, gate_out, step_idx, step_pulse, running} !== {held, 1'b0, IW'(0), 1'b0, 1'b0})
            $display("FAIL start_stop: got %h expected %h",
                     {note_out, gate_out, step_idx, step_pulse, running}, {held, 1'b0, IW'(0), 1'b0, 1'b0});
        else n_pass++;
        clk_step();
        n_chk++;
        if (act_v !== exp_v) $display("FAIL start_stop_hold: got %h expected %h", act_v, exp_v);
        else n_pass++;
    endtask

    task automatic test_min_tempo();
        for (int t = 0; t < 2; t++) begin
            tempo_div = DIV_W'(t); gate_len = 1;
            do_start();
            for (int c = 0; c < 10; c++) begin
                n_chk++;
                if ({step_pulse, step_idx} !== {c % 2 == 0, IW'(c / 2)})
                    $display("FAIL min_tempo%0d_c%0d: got %h expected %h", t, c,
                             {step_pulse, step_idx}, {c % 2 == 0, IW'(c / 2)});
                else n_pass++;
                clk_step();
            end
            do_stop();
        end
    endtask

    task automatic test_legato();
        write_step(3, 13, 1);
        tempo_div = 4; gate_len = 7;
        do_start();
        for (int c = 0; c < 20; c++) begin
            n_chk++;
            if (gate_out !== 1'b1) $display("FAIL legato_c%0d: got %b expected 1", c, gate_out);
            else n_pass++;
            clk_step();
        end
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 8; seg++) begin
            do_stop();
            tempo_div = DIV_W'($urandom_range(0, 6));
            gate_len  = DIV_W'($urandom_range(0, 8));
`ifdef STEP_SEQ_SWING_EN
            swing_amt = (DIV_W-1)'($urandom_range(0, 4));
`endif
            do_start();
            for (int c = 0; c < 50; c++) begin
                n_chk++;
                if (act_v !== exp_v) $display("FAIL random_s%0d_c%0d: got %h expected %h", seg, c, act_v, exp_v);
                else n_pass++;
                wr_en   = ($urandom_range(0, 2) == 0);
                wr_addr = IW'($urandom_range(0, STEPS - 1));
                wr_note = NOTE_W'($urandom_range(0, 127));
                wr_gate = 1'($urandom_range(0, 1));
                start   = ($urandom_range(0, 29) == 0);
                stop    = ($urandom_range(0, 39) == 0);
                clk_step();
                wr_en = 0; start = 0; stop = 0;
            end
        end
`ifdef STEP_SEQ_SWING_EN
        swing_amt = '0;
`endif
    endtask

    task automatic test_async_reset();
        do_stop();
        for (int i = 0; i < STEPS; i++) write_step(i, 20 + i, 1);
        tempo_div = 4; gate_len = 2;
        do_start();
        repeat (21) clk_step();
        #2 reset_n = 0;
        #1;
        n_chk++;
        if ({note_out, gate_out, step_idx, step_pulse, running} !== '0)
            $display("FAIL async_reset: got %h expected 0", {note_out, gate_out, step_idx, step_pulse, running});
        else n_pass++;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        clk_step();
        n_chk++;
        if (running !== 1'b0) $display("FAIL reset_running: got %b expected 0", running);
        else n_pass++;
        do_start();
        for (int c = 0; c < 32; c++) begin
            n_chk++;
            if ({note_out, gate_out} !== '0 || act_v !== exp_v)
                $display("FAIL cleared_pattern_c%0d: got %h expected %h", c, act_v, exp_v);
            else n_pass++;
            clk_step();
        end
    endtask

`ifdef STEP_SEQ_SWING_EN
    task automatic test_swing();
        int want[2][4] = '{'{10, 6, 10, 6}, '{11, 5, 11, 5}};
        int len;
        tempo_div = 8; gate_len = 3;
        for (int k = 0; k < 2; k++) begin
            do_stop();
            swing_amt = (k == 0) ? (DIV_W-1)'(2) : (DIV_W-1)'(9);
            do_start();
            for (int j = 0; j < 4; j++) begin
                len = 0;
                do begin
                    clk_step();
                    len++;
                end while (step_pulse !== 1'b1 && len < 40);
                n_chk++;
                if (len !== want[k][j] || act_v !== exp_v)
                    $display("FAIL swing%0d_step%0d: got %0d cycles expected %0d", k, j, len, want[k][j]);
                else n_pass++;
            end
        end
        swing_amt = '0;
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_rest();
        test_start_stop();
        test_min_tempo();
        test_legato();
        test_random();
`ifdef STEP_SEQ_SWING_EN
        test_swing();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
